gray_vid_tx: RTL and testbench



---
 rtl/gray_vid_tx.sv | 154 +++++++++++++++
 tb/tb_gray_vid_tx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_vid_tx.sv
// Raster timing generator and gray-pixel frame player.
// Fetches pixels over a 1-cycle read port; pixel/hs/vs/de leave aligned.
module gray_vid_tx #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int ADDR_W   = 20
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              tx_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        oGray,
    output logic              hs,
    output logic              vs,
    output logic              de,
    output logic              frame_start,
    output logic              frame_done
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_MAX  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_LPIX = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_MAX  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_LPIX = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t state, state_nx;
    logic fl_cnt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    logic run, wrap, act, hs_t, vs_t, first_t, last_t;
    logic hs1, vs1, first1, last1;
    logic de2, hs2, vs2, first2, last2;
    logic last3;

    assign run  = (state == RUN);
    assign wrap = run && (h_cnt == H_MAX) && (v_cnt == V_MAX);
    assign act  = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_t = run && (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_t = run && (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign first_t = act && (h_cnt == '0) && (v_cnt == '0);
    assign last_t  = act && (h_cnt == H_LPIX) && (v_cnt == V_LPIX);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            fl_cnt <= 1'b0;
        end else begin
            state  <= state_nx;
            fl_cnt <= (state == FLUSH) ? ~fl_cnt : 1'b0;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (tx_en) state_nx = RUN;
            RUN:     if (wrap && !tx_en) state_nx = FLUSH;
            FLUSH:   if (fl_cnt) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!run || wrap) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_MAX) begin
            h_cnt <= '0;
            v_cnt <= v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Address clears after the last pixel so it reads 0 through blanking.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr <= '0;
        end else if (!run || wrap) begin
            rd_addr <= '0;
        end else if (rd_en) begin
            rd_addr <= last1 ? '0 : rd_addr + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rd_en       <= 1'b0;
            hs1         <= 1'b0;
            vs1         <= 1'b0;
            first1      <= 1'b0;
            last1       <= 1'b0;
            de2         <= 1'b0;
            hs2         <= 1'b0;
            vs2         <= 1'b0;
            first2      <= 1'b0;
            last2       <= 1'b0;
            de          <= 1'b0;
            hs          <= 1'b0;
            vs          <= 1'b0;
            frame_start <= 1'b0;
            last3       <= 1'b0;
            oGray       <= 8'd0;
            frame_done  <= 1'b0;
        end else begin
            rd_en       <= act;
            hs1         <= hs_t;
            vs1         <= vs_t;
            first1      <= first_t;
            last1       <= last_t;
            de2         <= rd_en;
            hs2         <= hs1;
            vs2         <= vs1;
            first2      <= first1;
            last2       <= last1;
            de          <= de2;
            hs          <= hs2;
            vs          <= vs2;
            frame_start <= first2;
            last3       <= last2;
            oGray       <= de2 ? rd_data : 8'd0;
            frame_done  <= last3;
        end
    end

endmodule

// File: tb/tb_gray_vid_tx.sv
// Bench for gray_vid_tx: randomized tx_en against a frame-position model.
// Small raster: 8 clocks/line, 6 lines/frame, 12 pixels.
module tb_gray_vid_tx;

    localparam int HA = 4, HF = 1, HSY = 2, HB = 1;
    localparam int VA = 3, VF = 1, VSY = 1, VB = 1;
    localparam int AW = 8;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int FT = HT * VT;
    localparam int NPIX = HA * VA;

    logic          clock;
    logic          rst_n;
    logic          tx_en;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [7:0]    oGray;
    logic          hs, vs, de;
    logic          frame_start, frame_done;

    gray_vid_tx #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .ADDR_W(AW)
    ) dut (
        .clock(clock),
        .rst_n(rst_n),
        .tx_en(tx_en),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .oGray(oGray),
        .hs(hs),
        .vs(vs),
        .de(de),
        .frame_start(frame_start),
        .frame_done(frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    logic [7:0] mem [NPIX];

    always @(posedge clock) begin
        if (rd_en && rd_addr < NPIX)
            rd_data <= mem[rd_addr];
        else
            rd_data <= 8'($urandom);
    end

    function automatic bit is_act(int p);
        return p >= 0 && (p % HT) < HA && (p / HT) < VA;
    endfunction

    function automatic bit is_hs(int p);
        return p >= 0 && (p % HT) >= HA + HF && (p % HT) < HA + HF + HSY;
    endfunction

    function automatic bit is_vs(int p);
        return p >= 0 && (p / HT) >= VA + VF && (p / HT) < VA + VF + VSY;
    endfunction

    function automatic int pix(int p);
        return (p / HT) * HA + (p % HT);
    endfunction

    // Frame position held by the counters each cycle (-1 when not running),
    // plus its history: outputs are a fixed number of cycles behind it.
    int cur = -1, p1 = -1, p2 = -1, p3 = -1, p4 = -1;
    int mflush = 0;
    bit mrun = 0;

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cur = -1; p1 = -1; p2 = -1; p3 = -1; p4 = -1;
            mflush = 0;
            mrun = 0;
        end else begin
            p4 = p3; p3 = p2; p2 = p1; p1 = cur;
            if (mrun) begin
                if (cur == FT - 1) begin
                    if (tx_en) cur = 0;
                    else begin
                        mrun = 0; cur = -1; mflush = 2;
                    end
                end else begin
                    cur++;
                end
            end else if (mflush > 0) begin
                mflush--;
            end else if (tx_en) begin
                mrun = 1; cur = 0;
            end
        end
    end

    int cyc = 0;
    int n_fs = 0, n_fd = 0;
    int last_fs = -1, last_fd = -1;
    bit gap_on = 0;

    always @(negedge clock) begin
        cyc++;
        check("rd_en", rd_en, is_act(p1));
        if (is_act(p1)) check("rd_addr", rd_addr, pix(p1));
        check("de", de, is_act(p3));
        check("hs", hs, is_hs(p3));
        check("vs", vs, is_vs(p3));
        check("ogray", oGray, is_act(p3) ? mem[pix(p3)] : 8'd0);
        check("fstart", frame_start, is_act(p3) && pix(p3) == 0);
        check("fdone", frame_done, is_act(p4) && pix(p4) == NPIX - 1);
        if (frame_start) begin
            n_fs++;
            check("fs_pix0", oGray, mem[0]);
            if (gap_on && last_fs >= 0) check("fs_period", cyc - last_fs, FT);
            last_fs = cyc;
        end
        if (frame_done) begin
            n_fd++;
            if (gap_on && last_fd >= 0) check("fd_period", cyc - last_fd, FT);
            last_fd = cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        tx_en = 1'b0;
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
        step(3);
        check("rst_de", de, 0);
        check("rst_addr", rd_addr, 0);
        rst_n = 1'b1;
        step(5);

        // Back-to-back frames
        n_fs = 0; n_fd = 0; last_fs = -1; last_fd = -1; gap_on = 1;
        tx_en = 1'b1;
        step(2 * FT + 20);
        tx_en = 1'b0;
        step(FT + 10);
        gap_on = 0;
        check("b2b_starts", n_fs, 3);
        check("b2b_dones", n_fd, 3);

        // Stop mid-frame
        n_fs = 0; n_fd = 0;
        tx_en = 1'b1;
        step(15);
        tx_en = 1'b0;
        step(FT + 10);
        check("stop_starts", n_fs, 1);
        check("stop_dones", n_fd, 1);
        check("stop_rd_en", rd_en, 0);

        // Reset mid-frame
        tx_en = 1'b1;
        step(12);
        rst_n = 1'b0;
        #1;
        check("mrst_de", de, 0);
        check("mrst_rd_en", rd_en, 0);
        check("mrst_ogray", oGray, 0);
        check("mrst_addr", rd_addr, 0);
        check("mrst_hs", hs, 0);
        step(1);
        rst_n = 1'b1;
        n_fs = 0;
        step(FT + 10);
        tx_en = 1'b0;
        step(FT + 10);
        check("mrst_restart", n_fs, 2);

        // Random tx_en toggling in every state
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 900; i++) begin
            step(1);
            if ($urandom_range(0, 29) == 0) tx_en = ~tx_en;
        end
        tx_en = 1'b0;
        step(FT + 10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
